// File: rtl/prim_mem_bridge_if.sv
// rtl/prim_mem_bridge_if.sv - CPU and byte-memory bus bundle for prim_mem_bridge
interface prim_mem_bridge_if;
  logic [15:0] i_addr;
  logic [15:0] i_dat;
  logic [1:0]  i_bs;
  logic        i_we;
  logic [15:0] o_dat;
  logic        o_ack;
  logic [15:0] o_mem_addr;
  logic [7:0]  o_mem_dat;
  logic [7:0]  i_mem_dat;
  logic        o_mem_we;
  logic        o_mem_oe;

  // CPU and memory model side
  modport master (
    output i_addr, i_dat, i_bs, i_we, i_mem_dat,
    input  o_dat, o_ack, o_mem_addr, o_mem_dat, o_mem_we, o_mem_oe
  );

  // Bridge side
  modport slave (
    input  i_addr, i_dat, i_bs, i_we, i_mem_dat,
    output o_dat, o_ack, o_mem_addr, o_mem_dat, o_mem_we, o_mem_oe
  );
endinterface

// File: rtl/prim_mem_bridge.sv
// rtl/prim_mem_bridge.sv - 16-bit CPU to 8-bit memory bridge; wait states enabled by PRIM_MEM_BRIDGE_WAIT_EN
module prim_mem_bridge #(
  parameter int WAIT = 1
) (
  input  logic             i_clk,
  input  logic             i_reset,
  prim_mem_bridge_if.slave io_bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_addr;
  logic [15:0] r_dat;
  logic [15:0] r_rdat;
  logic        r_word;
  logic        r_we;
  logic        w_accept;
  logic        w_phase_last;
  logic [15:0] w_mem_addr;
  logic [7:0]  w_mem_dat;
  logic        w_mem_we;
  logic        w_mem_oe;
  logic        w_ack;

  assign w_accept = (r_state == ST_IDLE) && (io_bus.i_bs != 2'b00);

`ifdef PRIM_MEM_BRIDGE_WAIT_EN
  localparam int CW = (WAIT > 0) ? $clog2(WAIT + 1) : 1;

  logic [CW-1:0] r_wait;
  logic          w_phase_enter;

  assign w_phase_enter = (w_next != r_state) && ((w_next == ST_LO) || (w_next == ST_HI));

  // Reload on each LO/HI entry, then count down; zero marks the final edge of the phase
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_wait <= '0;
    end else if (w_phase_enter) begin
      r_wait <= CW'(WAIT);
    end else if (r_wait != '0) begin
      r_wait <= r_wait - 1'b1;
    end
  end

  assign w_phase_last = (r_wait == '0);
`else
  logic w_unused_wait;

  assign w_unused_wait = ^WAIT;
  assign w_phase_last  = 1'b1;
`endif

  // State register; async reset aborts any transaction in flight
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state: LO always first, HI only for word access, DONE for one ack cycle
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_next = ST_LO;
      ST_LO:   if (w_phase_last) w_next = r_word ? ST_HI : ST_DONE;
      ST_HI:   if (w_phase_last) w_next = ST_DONE;
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Memory-side outputs decode straight from state so reset drops the strobes at once
  always_comb begin
    w_mem_addr = 16'h0000;
    w_mem_dat  = 8'h00;
    w_mem_we   = 1'b0;
    w_mem_oe   = 1'b0;
    w_ack      = 1'b0;
    case (r_state)
      ST_LO: begin
        w_mem_addr = r_addr;
        w_mem_dat  = r_dat[7:0];
        w_mem_we   = r_we;
        w_mem_oe   = ~r_we;
      end
      ST_HI: begin
        w_mem_addr = r_addr + 16'd1;
        w_mem_dat  = r_dat[15:8];
        w_mem_we   = r_we;
        w_mem_oe   = ~r_we;
      end
      ST_DONE: w_ack = 1'b1;
      default: ;
    endcase
  end

  // Request capture at acceptance and read-data capture on each phase's last edge
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_addr <= 16'h0000;
      r_dat  <= 16'h0000;
      r_word <= 1'b0;
      r_we   <= 1'b0;
      r_rdat <= 16'h0000;
    end else begin
      if (w_accept) begin
        r_addr <= io_bus.i_addr;
        r_dat  <= io_bus.i_dat;
        r_word <= (io_bus.i_bs == 2'b11);
        r_we   <= io_bus.i_we;
      end
      if ((r_state == ST_LO) && w_phase_last && !r_we) begin
        r_rdat <= {8'h00, io_bus.i_mem_dat};
      end
      if ((r_state == ST_HI) && w_phase_last && !r_we) begin
        r_rdat[15:8] <= io_bus.i_mem_dat;
      end
    end
  end

  assign io_bus.o_dat      = r_rdat;
  assign io_bus.o_ack      = w_ack;
  assign io_bus.o_mem_addr = w_mem_addr;
  assign io_bus.o_mem_dat  = w_mem_dat;
  assign io_bus.o_mem_we   = w_mem_we;
  assign io_bus.o_mem_oe   = w_mem_oe;

endmodule

// File: tb/tb_prim_mem_bridge.sv
// tb/tb_prim_mem_bridge.sv - scoreboard bench for prim_mem_bridge
`timescale 1ns/1ps
module tb_prim_mem_bridge;

`ifdef PRIM_MEM_BRIDGE_WAIT_EN
  localparam int W = 2;
`else
  localparam int W = 0;
`endif
  localparam int LAT_BYTE = (1 + W) + 1;
  localparam int LAT_WORD = 2 * (1 + W) + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  prim_mem_bridge_if bus ();

  prim_mem_bridge #(.WAIT(2)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .io_bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  logic [7:0] mem [0:65535];

  assign bus.i_mem_dat = mem[bus.o_mem_addr];

  always @(posedge clk) begin
    if (!rst && bus.o_mem_we) mem[bus.o_mem_addr] = bus.o_mem_dat;
  end

  typedef struct {
    logic [15:0] dat;
    logic        rd;
    int          acc;
    int          lat;
    string       name;
  } ack_t;

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  dat;
    logic        we;
  } op_t;

  ack_t ackq[$];
  op_t  opq[$];
  ack_t a;
  op_t  o;
  logic        prev_act = 1'b0;
  logic [15:0] prev_addr = 16'h0000;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      prev_act = 1'b0;
    end else begin
      if (bus.o_ack) begin
        if (ackq.size() == 0) begin
          chk("unexpected_ack", 32'd1, 32'd0);
        end else begin
          a = ackq.pop_front();
          if (a.rd) chk({a.name, "_dat"}, {16'h0, bus.o_dat}, {16'h0, a.dat});
          chk({a.name, "_lat"}, cyc - a.acc + 1, a.lat);
        end
      end
      if ((bus.o_mem_we || bus.o_mem_oe) && (!prev_act || bus.o_mem_addr != prev_addr)) begin
        if (opq.size() == 0) begin
          chk("unexpected_memop", 32'd1, 32'd0);
        end else begin
          o = opq.pop_front();
          chk("memop_addr", {16'h0, bus.o_mem_addr}, {16'h0, o.addr});
          chk("memop_we", {31'h0, bus.o_mem_we}, {31'h0, o.we});
          chk("memop_oe", {31'h0, bus.o_mem_oe}, {31'h0, ~o.we});
          if (o.we) chk("memop_dat", {24'h0, bus.o_mem_dat}, {24'h0, o.dat});
        end
      end
      prev_act  = bus.o_mem_we || bus.o_mem_oe;
      prev_addr = bus.o_mem_addr;
    end
  end

  task automatic push_ops(input logic [1:0] bs, input logic we, input logic [15:0] addr,
                          input logic [15:0] dat);
    opq.push_back('{addr: addr, dat: dat[7:0], we: we});
    if (bs == 2'b11) opq.push_back('{addr: addr + 16'd1, dat: dat[15:8], we: we});
  endtask

  task automatic wait_ack(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.o_ack && n < 40);
    if (!bus.o_ack) chk({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic issue(input string name, input logic [1:0] bs, input logic we,
                       input logic [15:0] addr, input logic [15:0] dat, input logic [15:0] exp_rd);
    @(negedge clk);
    bus.i_bs   = bs;
    bus.i_we   = we;
    bus.i_addr = addr;
    bus.i_dat  = dat;
    ackq.push_back('{dat: exp_rd, rd: ~we, acc: cyc + 1,
                     lat: (bs == 2'b11) ? LAT_WORD : LAT_BYTE, name: name});
    push_ops(bs, we, addr, dat);
    @(posedge clk);
    #1;
    bus.i_bs   = 2'b00;
    bus.i_we   = ~we;
    bus.i_addr = ~addr;
    bus.i_dat  = ~dat;
    wait_ack(name);
    @(posedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cycles=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'h1234] = 8'hA5;
    mem[16'hFFFF] = 8'h34;
    mem[16'h0000] = 8'h12;
    mem[16'h4001] = 8'h99;
    bus.i_bs   = 2'b00;
    bus.i_we   = 1'b0;
    bus.i_addr = 16'h0000;
    bus.i_dat  = 16'h0000;

    repeat (2) @(negedge clk);
    chk("rst_ack", {31'h0, bus.o_ack}, 32'd0);
    chk("rst_dat", {16'h0, bus.o_dat}, 32'd0);
    chk("rst_mem_addr", {16'h0, bus.o_mem_addr}, 32'd0);
    chk("rst_mem_dat", {24'h0, bus.o_mem_dat}, 32'd0);
    chk("rst_mem_we", {31'h0, bus.o_mem_we}, 32'd0);
    chk("rst_mem_oe", {31'h0, bus.o_mem_oe}, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    issue("rd_byte_1234", 2'b01, 1'b0, 16'h1234, 16'h0000, 16'h00A5);
    issue("wr_word_2000", 2'b11, 1'b1, 16'h2000, 16'hBEEF, 16'h0000);
    issue("rd_word_2000", 2'b11, 1'b0, 16'h2000, 16'h0000, 16'hBEEF);
    issue("rd_bs10_2001", 2'b10, 1'b0, 16'h2001, 16'h0000, 16'h00BE);
    issue("rd_word_wrap", 2'b11, 1'b0, 16'hFFFF, 16'h0000, 16'h1234);
    issue("wr_byte_4000", 2'b01, 1'b1, 16'h4000, 16'hAA55, 16'h0000);
    issue("rd_word_4000", 2'b11, 1'b0, 16'h4000, 16'h0000, 16'h9955);

    // Word write aborted by reset while the high byte is on the bus
    @(negedge clk);
    bus.i_bs   = 2'b11;
    bus.i_we   = 1'b1;
    bus.i_addr = 16'h3000;
    bus.i_dat  = 16'h5678;
    push_ops(2'b11, 1'b1, 16'h3000, 16'h5678);
    @(posedge clk);
    #1;
    bus.i_bs = 2'b00;
    n = 0;
    while (!(bus.o_mem_addr == 16'h3001 && bus.o_mem_we) && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("abort_hi_reached", {31'h0, bus.o_mem_we}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("abort_we_async", {31'h0, bus.o_mem_we}, 32'd0);
    chk("abort_ack", {31'h0, bus.o_ack}, 32'd0);
    chk("abort_mem_addr", {16'h0, bus.o_mem_addr}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_idle_we", {31'h0, bus.o_mem_we}, 32'd0);
    chk("abort_idle_oe", {31'h0, bus.o_mem_oe}, 32'd0);
    issue("rd_word_3000", 2'b11, 1'b0, 16'h3000, 16'h0000, 16'h0078);

    // Back-to-back byte reads with i_bs held and the address swapped after the first ack
    @(negedge clk);
    bus.i_bs   = 2'b01;
    bus.i_we   = 1'b0;
    bus.i_addr = 16'h1234;
    ackq.push_back('{dat: 16'h00A5, rd: 1'b1, acc: cyc + 1, lat: LAT_BYTE, name: "b2b_first"});
    push_ops(2'b01, 1'b0, 16'h1234, 16'h0000);
    wait_ack("b2b_first");
    bus.i_addr = 16'h2000;
    ackq.push_back('{dat: 16'h00EF, rd: 1'b1, acc: cyc + 2, lat: LAT_BYTE, name: "b2b_second"});
    push_ops(2'b01, 1'b0, 16'h2000, 16'h0000);
    wait_ack("b2b_second");
    bus.i_bs = 2'b00;

    repeat (4) @(negedge clk);
    chk("ackq_drained", ackq.size(), 32'd0);
    chk("opq_drained", opq.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
